// File: rtl/ksa_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined Kogge-Stone adder.
// The master side drives operands and consumes results; the slave is the adder.
interface ksa_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: pre-process stage, one register per
// prefix level, and a registered post-process stage, all under one advance enable.
module ksa_pipe #(
    parameter  int WIDTH = 16,
    localparam int LOGW  = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          rst_n,
    ksa_pipe_if.slave    bus
);
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("ksa_pipe: WIDTH must be a power of two in 4..64");
    end

    // Stage k (0..LOGW) registers; index 0 is the pre-process stage.
    logic             v_q  [LOGW+1];
    logic [WIDTH-1:0] gg_q [LOGW+1];
    logic [WIDTH-1:0] pp_q [LOGW+1];
    logic [WIDTH-1:0] p_q  [LOGW+1];
    logic             c_q  [LOGW+1];
    logic             am_q [LOGW+1];
    logic             bm_q [LOGW+1];

    logic             v_nxt  [LOGW+1];
    logic [WIDTH-1:0] gg_nxt [LOGW+1];
    logic [WIDTH-1:0] pp_nxt [LOGW+1];
    logic [WIDTH-1:0] p_nxt  [LOGW+1];
    logic             c_nxt  [LOGW+1];
    logic             am_nxt [LOGW+1];
    logic             bm_nxt [LOGW+1];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] sum_nxt;
    logic             advance;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        c_eff = bus.sub | bus.cin;

        // Carry-in is folded into bit 0 as a generate from position -1.
        v_nxt[0]     = bus.in_valid;
        p_nxt[0]     = bus.a ^ b_eff;
        pp_nxt[0]    = bus.a ^ b_eff;
        gg_nxt[0]    = bus.a & b_eff;
        gg_nxt[0][0] = (bus.a[0] & b_eff[0]) | (p_nxt[0][0] & c_eff);
        c_nxt[0]     = c_eff;
        am_nxt[0]    = bus.a[WIDTH-1];
        bm_nxt[0]    = b_eff[WIDTH-1];

        for (int k = 1; k <= LOGW; k++) begin
            v_nxt[k]  = v_q[k-1];
            p_nxt[k]  = p_q[k-1];
            c_nxt[k]  = c_q[k-1];
            am_nxt[k] = am_q[k-1];
            bm_nxt[k] = bm_q[k-1];
            gg_nxt[k] = gg_q[k-1];
            pp_nxt[k] = pp_q[k-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (k - 1))) begin
                    gg_nxt[k][i] = gg_q[k-1][i] | (pp_q[k-1][i] & gg_q[k-1][i - (1 << (k - 1))]);
                    pp_nxt[k][i] = pp_q[k-1][i] & pp_q[k-1][i - (1 << (k - 1))];
                end
            end
        end

        // After the last level gg holds the carry out of each bit position.
        sum_nxt = p_q[LOGW] ^ {gg_q[LOGW][WIDTH-2:0], c_q[LOGW]};
    end

    // NOTE: data registers are reset along with valid bits so no stale value shows after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LOGW; k++) begin
                v_q[k]  <= 1'b0;
                gg_q[k] <= '0;
                pp_q[k] <= '0;
                p_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                am_q[k] <= 1'b0;
                bm_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k <= LOGW; k++) begin
                v_q[k]  <= v_nxt[k];
                gg_q[k] <= gg_nxt[k];
                pp_q[k] <= pp_nxt[k];
                p_q[k]  <= p_nxt[k];
                c_q[k]  <= c_nxt[k];
                am_q[k] <= am_nxt[k];
                bm_q[k] <= bm_nxt[k];
            end
            out_valid_q <= v_q[LOGW];
            sum_q       <= sum_nxt;
            cout_q      <= gg_q[LOGW][WIDTH-1];
            ovf_q       <= (am_q[LOGW] == bm_q[LOGW]) && (sum_nxt[WIDTH-1] != am_q[LOGW]);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ksa_pipe.sv
// Directed bench for ksa_pipe at WIDTH=16: vector table with latency checks,
// a backpressured stream, and an asynchronous reset in the middle of traffic.
module tb_ksa_pipe;
    localparam int WIDTH = 16;
    localparam int LAT   = 5;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    vec_t vecs [12];

    ksa_pipe_if #(.WIDTH(WIDTH)) bus ();

    ksa_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one beat into an empty pipeline and verify latency, result and one-cycle pulse.
    task automatic send_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        bus.a         = v.a;
        bus.b         = v.b;
        bus.cin       = v.cin;
        bus.sub       = v.sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " sum"},  64'(bus.sum),  64'(v.sum));
        check({tag, " cout"}, 64'(bus.cout), 64'(v.cout));
        check({tag, " ovf"},  64'(bus.ovf),  64'(v.ovf));
        @(posedge clk);
        #1 check({tag, " pulse"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int got;
        int stall_left;
        int cyc;
        int first_cyc;
        int last_cyc;
        int extra;
        vec_t v;

        errors = 0;
        checks = 0;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[11] = '{16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset sum",       64'(bus.sum),       64'd0);
        check("reset cout",      64'(bus.cout),      64'd0);
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send_one(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with a three-cycle consumer stall after the second result.
        sent = 0; got = 0; stall_left = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        @(posedge clk);
        while (got < 8 && cyc < 200) begin
            #1;
            bus.out_ready = (stall_left == 0);
            bus.cin       = 1'b0;
            bus.sub       = 1'b0;
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'(sent);
                bus.b        = 16'(16'h0100 * sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (stall_left > 0) begin
                check("stall in_ready",  64'(bus.in_ready),  64'd0);
                check("stall out_valid", 64'(bus.out_valid), 64'd1);
                check("stall sum held",  64'(bus.sum),       64'(16'(16'h0101 * got)));
                stall_left--;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream sum%0d", got), 64'(bus.sum), 64'(16'(16'h0101 * got)));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
                if (got == 2) stall_left = 3;
            end
            @(posedge clk);
            cyc++;
        end
        check("stream count", 64'(got), 64'd8);
        check("stream span",  64'(last_cyc - first_cyc), 64'd10);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("stream no duplicates", 64'(extra), 64'd0);

        // Three beats in flight, first one parked at the output, then reset between edges.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = 16'hFFFF;
            bus.b        = 16'(3 + i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        check("pre-reset sum",       64'(bus.sum),       64'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("async out_valid", 64'(bus.out_valid), 64'd0);
        check("async sum",       64'(bus.sum),       64'd0);
        check("async cout",      64'(bus.cout),      64'd0);
        check("async in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("post-reset stale", 64'(extra), 64'd0);
        v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        send_one(v, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
